// File: rtl/guard_reset_ctrl.sv
// guard_reset_ctrl
//   Recovery sequencer for the AXI read/write guards. A reset request from
//   either guard (while enabled) starts a fixed recovery sequence:
//   isolate the slave, drain outstanding transactions, hold the slave in
//   reset, release it, then re-arm the guards once software has acknowledged
//   the interrupt (or immediately when AutoRecover is set).
//
//   Ports
//     clk_i, rst_ni       clock, asynchronous active-low reset
//     enable_i            software guard enable
//     rd_reset_req_i      reset request from the read guard
//     wr_reset_req_i      reset request from the write guard
//     outstanding_i       a guard still holds a live transaction
//     irq_ack_i           software interrupt clear pulse
//     guard_ena_o         enable to both guards (only while idle)
//     isolate_o           blocks AXI handshakes between master and slave
//     slv_rst_no          active-low reset to the protected slave
//     reset_clear_o       one-cycle pulse clearing guard reset/irq latches
//     irq_o               sticky fault interrupt
//     cause_o             {wr, rd} request snapshot of the last accepted fault
//     fault_cnt_o         saturating count of accepted faults
//     busy_o              sequencer not idle
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | guards armed, waiting for an enabled reset request
//   DRAIN    | slave isolated, waiting for outstanding traffic (bounded)
//   RESET    | slave reset asserted for RstCycles (from the cycle after entry)
//   RECOVER  | slave out of reset, still isolated, settling time
//   WAIT_ACK | recovery done, waiting for the interrupt to be acknowledged

module guard_reset_ctrl #(
  parameter int unsigned DrainCycles   = 64,
  parameter int unsigned RstCycles     = 16,
  parameter int unsigned RecoverCycles = 8,
  parameter int unsigned CntWidth      = 8,
  parameter int unsigned FaultCntWidth = 16,
  parameter bit          AutoRecover   = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     rd_reset_req_i,
  input  logic                     wr_reset_req_i,
  input  logic                     outstanding_i,
  input  logic                     irq_ack_i,
  output logic                     guard_ena_o,
  output logic                     isolate_o,
  output logic                     slv_rst_no,
  output logic                     reset_clear_o,
  output logic                     irq_o,
  output logic [1:0]               cause_o,
  output logic [FaultCntWidth-1:0] fault_cnt_o,
  output logic                     busy_o
);

  localparam longint unsigned CntMax = (64'd1 << CntWidth) - 64'd1;

  if (CntWidth < 1 || CntWidth > 32) begin : g_bad_cnt_width
    $fatal(1, "guard_reset_ctrl: CntWidth must be 1..32");
  end
  if (FaultCntWidth < 1) begin : g_bad_fault_width
    $fatal(1, "guard_reset_ctrl: FaultCntWidth must be >= 1");
  end
  if (DrainCycles < 1 || longint'(DrainCycles) > CntMax) begin : g_bad_drain
    $fatal(1, "guard_reset_ctrl: DrainCycles out of range for CntWidth");
  end
  if (RstCycles < 1 || longint'(RstCycles) > CntMax) begin : g_bad_rst
    $fatal(1, "guard_reset_ctrl: RstCycles out of range for CntWidth");
  end
  if (RecoverCycles < 1 || longint'(RecoverCycles) > CntMax) begin : g_bad_recover
    $fatal(1, "guard_reset_ctrl: RecoverCycles out of range for CntWidth");
  end

  // Terminal counts. RESET runs one cycle longer than RstCycles because the
  // registered slave reset only goes low the cycle after entry.
  localparam logic [CntWidth-1:0] DrainLast   = CntWidth'(DrainCycles - 1);
  localparam logic [CntWidth-1:0] RstLast     = CntWidth'(RstCycles);
  localparam logic [CntWidth-1:0] RecoverLast = CntWidth'(RecoverCycles - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_RESET    = 3'd2,
    ST_RECOVER  = 3'd3,
    ST_WAIT_ACK = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [CntWidth-1:0]      cnt_q, cnt_d;
  logic                     irq_q, irq_d;
  logic [1:0]               cause_q, cause_d;
  logic [FaultCntWidth-1:0] fault_cnt_q, fault_cnt_d;
  logic                     slv_rst_nq, slv_rst_nd;
  logic                     fault_accept;
  logic                     reset_clear;

  assign fault_accept = (state_q == ST_IDLE) && enable_i &&
                        (rd_reset_req_i || wr_reset_req_i);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cause_d     = cause_q;
    fault_cnt_d = fault_cnt_q;
    reset_clear = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fault_accept) begin
          state_d = ST_DRAIN;
          cause_d = {wr_reset_req_i, rd_reset_req_i};
          if (fault_cnt_q != '1) begin
            fault_cnt_d = fault_cnt_q + FaultCntWidth'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!outstanding_i || (cnt_q == DrainLast)) begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      ST_RESET: begin
        if (cnt_q == RstLast) begin
          state_d = ST_RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      ST_RECOVER: begin
        if (cnt_q == RecoverLast) begin
          reset_clear = 1'b1;
          state_d     = AutoRecover ? ST_IDLE : ST_WAIT_ACK;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      ST_WAIT_ACK: begin
        if (!irq_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // New fault has priority over a coincident acknowledge.
  always_comb begin
    irq_d = irq_q;
    if (fault_accept) begin
      irq_d = 1'b1;
    end else if (irq_ack_i) begin
      irq_d = 1'b0;
    end
  end

  // Registered so the slave sees a glitch-free reset; low while in RESET
  // except on its final (terminal-count) cycle.
  always_comb begin
    slv_rst_nd = 1'b1;
    if ((state_q == ST_RESET) && (cnt_q != RstLast)) begin
      slv_rst_nd = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      irq_q       <= 1'b0;
      cause_q     <= 2'b00;
      fault_cnt_q <= '0;
      slv_rst_nq  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      irq_q       <= irq_d;
      cause_q     <= cause_d;
      fault_cnt_q <= fault_cnt_d;
      slv_rst_nq  <= slv_rst_nd;
    end
  end

  assign guard_ena_o   = enable_i && (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign isolate_o     = (state_q != ST_IDLE);
  assign slv_rst_no    = slv_rst_nq;
  assign reset_clear_o = reset_clear;
  assign irq_o         = irq_q;
  assign cause_o       = cause_q;
  assign fault_cnt_o   = fault_cnt_q;

endmodule

// File: tb/tb_guard_reset_ctrl.sv
module tb_guard_reset_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, rd, wr, outst, ack;
  logic        guard_ena, isolate, slv_rst_n, reset_clear, irq, busy;
  logic [1:0]  cause;
  logic [15:0] fault_cnt;

  logic        en2, rd2;
  logic        guard_ena2, isolate2, slv_rst_n2, reset_clear2, irq2, busy2;
  logic [1:0]  cause2;
  logic [1:0]  fault_cnt2;

  always #5 clk = ~clk;

  guard_reset_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .rd_reset_req_i(rd), .wr_reset_req_i(wr), .outstanding_i(outst),
    .irq_ack_i(ack), .guard_ena_o(guard_ena), .isolate_o(isolate),
    .slv_rst_no(slv_rst_n), .reset_clear_o(reset_clear), .irq_o(irq),
    .cause_o(cause), .fault_cnt_o(fault_cnt), .busy_o(busy)
  );

  guard_reset_ctrl #(
    .DrainCycles(4), .RstCycles(2), .RecoverCycles(2), .CntWidth(3),
    .FaultCntWidth(2), .AutoRecover(1'b1)
  ) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en2),
    .rd_reset_req_i(rd2), .wr_reset_req_i(1'b0), .outstanding_i(1'b0),
    .irq_ack_i(1'b0), .guard_ena_o(guard_ena2), .isolate_o(isolate2),
    .slv_rst_no(slv_rst_n2), .reset_clear_o(reset_clear2), .irq_o(irq2),
    .cause_o(cause2), .fault_cnt_o(fault_cnt2), .busy_o(busy2)
  );

  typedef struct {
    logic [1:0]  cause;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_cnt = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request that the bench knows will be accepted; record expectation.
  task automatic drive_fault(input logic r, input logic w);
    rd = r;
    wr = w;
    if (exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
    sb.push_back('{cause: {w, r}, cnt: exp_cnt});
  endtask

  // Called on the first DRAIN cycle: compare snapshot against the scoreboard.
  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_cause"}, {30'd0, cause}, {30'd0, e.cause});
      chk({tag, "_fault_cnt"}, {16'd0, fault_cnt}, {16'd0, e.cnt});
    end
  endtask

  // Follows the sequence from the first DRAIN cycle (t=0) up to the
  // reset_clear pulse. Times are in cycles relative to t=0.
  task automatic observe_seq(input int drop_at, input bit inject,
                             output int first_low, output int n_low,
                             output int clr_t, output int iso_gaps);
    int t;
    bit seen;
    t = 0; seen = 0; first_low = -1; n_low = 0; clr_t = -1; iso_gaps = 0;
    while (!seen && t < 300) begin
      tick();
      t++;
      if (t == drop_at) outst = 1'b0;
      if (!isolate) iso_gaps++;
      if (!slv_rst_n) begin
        if (first_low < 0) first_low = t;
        n_low++;
      end
      if (inject) begin
        rd = !slv_rst_n && (n_low <= 3);
        wr = !slv_rst_n && (n_low <= 3);
      end
      if (reset_clear) begin
        clr_t = t;
        seen  = 1'b1;
      end
    end
    rd = 1'b0;
    wr = 1'b0;
    chk("seq_reached_clear", {31'd0, seen}, 32'd1);
  endtask

  // From the reset_clear cycle: one WAIT_ACK cycle, ack, then back to IDLE.
  task automatic finish_ack(input string tag);
    tick();
    chk({tag, "_clear_one_cycle"}, {31'd0, reset_clear}, 32'd0);
    chk({tag, "_wait_ack_busy"}, {31'd0, busy}, 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({tag, "_irq_acked"}, {31'd0, irq}, 32'd0);
    tick();
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_iso_off"}, {31'd0, isolate}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl, nl, ct, gaps, k, w;
    exp_t dummy;
    rst_n = 1'b0; enable = 1'b0; rd = 1'b0; wr = 1'b0; outst = 1'b0; ack = 1'b0;
    en2 = 1'b1; rd2 = 1'b0;
    #12;
    chk("rst_slv_rst_n", {31'd0, slv_rst_n}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_isolate", {31'd0, isolate}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_cause", {30'd0, cause}, 32'd0);
    chk("rst_fault_cnt", {16'd0, fault_cnt}, 32'd0);
    chk("rst_guard_ena", {31'd0, guard_ena}, 32'd0);
    chk("rst_reset_clear", {31'd0, reset_clear}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Requests while disabled are ignored.
    rd = 1'b1; wr = 1'b1;
    tick(); tick();
    rd = 1'b0; wr = 1'b0;
    chk("dis_busy", {31'd0, busy}, 32'd0);
    chk("dis_fault_cnt", {16'd0, fault_cnt}, 32'd0);
    enable = 1'b1;
    tick();
    chk("idle_guard_ena", {31'd0, guard_ena}, 32'd1);

    // 1: basic recovery, nothing outstanding.
    drive_fault(1'b1, 1'b0);
    tick();
    rd = 1'b0;
    chk("basic_drain_busy", {31'd0, busy}, 32'd1);
    chk("basic_isolate", {31'd0, isolate}, 32'd1);
    chk("basic_irq", {31'd0, irq}, 32'd1);
    chk("basic_guard_ena_off", {31'd0, guard_ena}, 32'd0);
    pop_check("basic");
    observe_seq(-1, 1'b0, fl, nl, ct, gaps);
    chk("basic_first_low", fl, 32'd2);
    chk("basic_low_len", nl, 32'd16);
    chk("basic_clear_at", ct, 32'd25);
    chk("basic_iso_held", gaps, 32'd0);
    tick(); tick();
    chk("basic_waits_for_ack", {31'd0, busy}, 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("basic_irq_cleared", {31'd0, irq}, 32'd0);
    tick();
    chk("basic_back_idle", {31'd0, busy}, 32'd0);
    chk("basic_guard_rearm", {31'd0, guard_ena}, 32'd1);
    chk("basic_cause_hold", {30'd0, cause}, 32'd1);

    // 2: forced drain, outstanding stuck high.
    outst = 1'b1;
    drive_fault(1'b0, 1'b1);
    tick();
    wr = 1'b0;
    pop_check("forced");
    observe_seq(-1, 1'b0, fl, nl, ct, gaps);
    chk("forced_first_low", fl, 32'd65);
    chk("forced_low_len", nl, 32'd16);
    chk("forced_clear_at", ct, 32'd88);
    outst = 1'b0;
    finish_ack("forced");

    // 3: early drain, outstanding drops during the sixth DRAIN cycle.
    outst = 1'b1;
    drive_fault(1'b1, 1'b0);
    tick();
    rd = 1'b0;
    pop_check("early");
    observe_seq(5, 1'b0, fl, nl, ct, gaps);
    chk("early_first_low", fl, 32'd7);
    chk("early_clear_at", ct, 32'd30);
    finish_ack("early");

    // 4: simultaneous rd/wr, then requests during RESET must be ignored.
    drive_fault(1'b1, 1'b1);
    tick();
    rd = 1'b0; wr = 1'b0;
    pop_check("both");
    observe_seq(-1, 1'b1, fl, nl, ct, gaps);
    chk("both_cnt_unchanged", {16'd0, fault_cnt}, {16'd0, exp_cnt});
    chk("both_cause_hold", {30'd0, cause}, 32'd3);
    finish_ack("both");

    // 5: ack during DRAIN, then a fault+ack on the first IDLE cycle.
    outst = 1'b1;
    drive_fault(1'b1, 1'b0);
    tick();
    rd = 1'b0;
    pop_check("early_ack");
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("early_ack_irq", {31'd0, irq}, 32'd0);
    chk("early_ack_still_drain", {31'd0, busy}, 32'd1);
    outst = 1'b0;
    observe_seq(-1, 1'b0, fl, nl, ct, gaps);
    tick();
    chk("early_ack_wait_one", {31'd0, busy}, 32'd1);
    tick();
    chk("early_ack_idle", {31'd0, busy}, 32'd0);
    drive_fault(1'b1, 1'b0);
    ack = 1'b1;
    tick();
    rd = 1'b0; ack = 1'b0;
    chk("set_wins_irq", {31'd0, irq}, 32'd1);
    chk("first_idle_accept", {31'd0, busy}, 32'd1);
    pop_check("first_idle");

    // 6: async reset while the slave is held in reset.
    tick(); tick();
    chk("pre_async_slv_low", {31'd0, slv_rst_n}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_slv_rst_n", {31'd0, slv_rst_n}, 32'd1);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_isolate", {31'd0, isolate}, 32'd0);
    chk("async_irq", {31'd0, irq}, 32'd0);
    chk("async_cause", {30'd0, cause}, 32'd0);
    chk("async_fault_cnt", {16'd0, fault_cnt}, 32'd0);
    chk("async_reset_clear", {31'd0, reset_clear}, 32'd0);
    exp_cnt = '0;
    chk("sb_drained", sb.size(), 32'd0);
    while (sb.size() > 0) dummy = sb.pop_front();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_async_idle", {31'd0, busy}, 32'd0);

    // Saturation and auto-recover on the narrow instance.
    for (k = 1; k <= 5; k++) begin
      rd2 = 1'b1;
      tick();
      rd2 = 1'b0;
      chk("sat_busy", {31'd0, busy2}, 32'd1);
      chk("sat_fault_cnt", {30'd0, fault_cnt2}, (k > 3) ? 32'd3 : k);
      w = 0;
      while (busy2 && w < 50) begin
        tick();
        w++;
      end
      chk("auto_recover_idle", {31'd0, busy2}, 32'd0);
    end
    chk("auto_irq_sticky", {31'd0, irq2}, 32'd1);
    chk("auto_guard_ena", {31'd0, guard_ena2}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/guard_reset_ctrl.md
Name: guard_reset_ctrl

Overview:
- Recovery sequencer for the AXI read/write guards.
- Accepts reset requests from the guards, then runs a fixed sequence: isolate the slave, drain outstanding transactions, reset the slave, release the slave, re-arm the guards.
- Sits between the guards, the slave's reset input and the register file (irq, cause, fault count).

Parameters:
- DrainCycles, 64, max cycles in DRAIN before forcing reset (>=1)
- RstCycles, 16, cycles slv_rst_no held low (>=1)
- RecoverCycles, 8, cycles after reset release before guards re-arm (>=1)
- CntWidth, 8, width of the shared phase counter; must hold max(DrainCycles, RstCycles, RecoverCycles)
- FaultCntWidth, 16, width of the saturating fault counter
- AutoRecover, 0, 1: skip WAIT_ACK and return to IDLE without software ack

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  software guard enable
- rd_reset_req_i  in  1  reset request from read guard
- wr_reset_req_i  in  1  reset request from write guard
- outstanding_i  in  1  1 while any guard holds a live transaction
- irq_ack_i  in  1  software irq clear (single-cycle pulse)
- guard_ena_o  out  1  enable to both guards
- isolate_o  out  1  1 blocks all AXI valid/ready between master and slave
- slv_rst_no  out  1  active-low reset to the protected slave
- reset_clear_o  out  1  one-cycle pulse clearing guard reset/irq latches
- irq_o  out  1  sticky fault interrupt
- cause_o  out  2  {wr, rd} request snapshot at detection
- fault_cnt_o  out  FaultCntWidth  saturating count of accepted faults
- busy_o  out  1  1 when state != IDLE

Behaviour:
- Reset values: state IDLE, guard_ena_o=0, isolate_o=0, slv_rst_no=1, reset_clear_o=0, irq_o=0, cause_o=0, fault_cnt_o=0, busy_o=0, phase counter 0.
- guard_ena_o = enable_i && state==IDLE (combinational); busy_o = state!=IDLE.
- FSM states: IDLE, DRAIN, RESET, RECOVER, WAIT_ACK.
- IDLE:
  - Fault = enable_i && (rd_reset_req_i || wr_reset_req_i).
  - On fault, next cycle: DRAIN; isolate_o=1; irq_o=1; cause_o={wr,rd}; fault_cnt_o+1, saturating at all-ones; counter cleared.
  - Requests while enable_i=0 are ignored.
- DRAIN:
  - isolate_o=1; counter increments each cycle.
  - Exit to RESET when !outstanding_i, or when counter==DrainCycles-1 (forced), whichever comes first.
  - Entry cycle counts as cycle 0. Counter cleared on exit.
- RESET:
  - slv_rst_no=0 for exactly RstCycles cycles, starting the cycle after entry.
  - Then RECOVER; counter cleared.
- RECOVER:
  - slv_rst_no=1, isolate_o=1, held for RecoverCycles cycles.
  - On the last cycle reset_clear_o=1 for one cycle.
  - Next state is WAIT_ACK, or IDLE if AutoRecover=1.
- WAIT_ACK:
  - isolate_o=1; go to IDLE when irq_o==0.
- IDLE after recovery: isolate_o=0 from the first IDLE cycle.
- irq_o:
  - Set on fault acceptance.
  - Cleared by irq_ack_i in any state.
  - If fault acceptance and irq_ack_i occur in the same cycle, set wins.
- cause_o holds its value until the next accepted fault.
- Guard requests in any non-IDLE state:
  - Ignored: no re-trigger, no count.
  - They are treated as symptoms of the isolation and reset.
- Early ack: irq_ack_i before WAIT_ACK clears irq_o, and WAIT_ACK exits after one cycle.
- Fault on the first IDLE cycle after recovery is accepted normally.
- rst_ni assertion mid-sequence returns everything to reset values immediately (slv_rst_no=1 asynchronously).
- Counter compares use CntWidth; a parameter exceeding 2^CntWidth-1 is a $fatal elaboration error.

Test Plan:
1. Basic recovery:
   - Stimulus: enable_i=1, AutoRecover=0, rd_reset_req_i pulse at cycle 10, outstanding_i=0.
   - Response: DRAIN at 11, RESET at 12, slv_rst_no low cycles 13–28, reset_clear_o pulse at cycle 36, WAIT_ACK until irq_ack_i, then guard_ena_o=1; cause_o=2'b01, fault_cnt_o=1.
2. Forced drain:
   - Stimulus: outstanding_i stuck at 1, DrainCycles=64.
   - Response: DRAIN lasts exactly 64 cycles before RESET.
3. Early drain:
   - Stimulus: outstanding_i drops after 5 DRAIN cycles.
   - Response: RESET is entered on the next cycle.
4. Simultaneous events:
   - Stimulus: rd and wr requests in the same cycle.
   - Response: cause_o=2'b11, fault_cnt_o increments by 1.
   - Stimulus: further requests during RESET.
   - Response: fault_cnt_o unchanged.
5. Ack handling:
   - Stimulus: irq_ack_i during DRAIN.
   - Response: irq_o=0; WAIT_ACK exits to IDLE after 1 cycle.
   - Stimulus: ack coincident with a new fault in IDLE.
   - Response: irq_o stays 1.
6. Async reset and saturation:
   - Stimulus: rst_ni low during RESET.
   - Response: slv_rst_no=1 immediately, state IDLE, outputs at reset values.
   - Stimulus: FaultCntWidth=2, 5 faults.
   - Response: fault_cnt_o saturates at 3.
